// File: rtl/dpwm_capture_pkg.sv
// dpwm_pkg: default widths, capture FSM states and
// the saturating-increment helper shared by dpwm_capture.
package dpwm_pkg;

  localparam int TON_W = 11;
  localparam int DT_W  = 5;
  localparam int PER_W = 12;
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    C1_ON,
    DT1,
    C2_ON,
    DT2
  } cap_st_t;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input int               w
  );
    logic [CNT_W-1:0] m;
    m = CNT_W'((32'd1 << w) - 32'd1);
    return (v >= m) ? m : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/dpwm_capture_if.sv
// dpwm_capture_if: measurement results bundle.
// master drives the results, slave observes them.
interface dpwm_capture_if #(
  parameter int TON_W = dpwm_pkg::TON_W,
  parameter int DT_W  = dpwm_pkg::DT_W,
  parameter int PER_W = dpwm_pkg::PER_W
);

  logic [TON_W-1:0] o_ton;
  logic [DT_W-1:0]  o_dt1;
  logic [TON_W-1:0] o_toff;
  logic [DT_W-1:0]  o_dt2;
  logic [PER_W-1:0] o_period;
  logic             o_valid;
  logic             o_err;

  modport master (
    output o_ton, o_dt1, o_toff,
    output o_dt2, o_period,
    output o_valid, o_err
  );

  modport slave (
    input o_ton, o_dt1, o_toff,
    input o_dt2, o_period,
    input o_valid, o_err
  );

endinterface

// File: rtl/dpwm_edge_sync.sv
// dpwm_edge_sync: level/rise/fall of one gate signal.
// DPWM_CAPTURE_SYNC_EN adds a 2-flop input synchronizer.
module dpwm_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_prev;
  logic w_lvl;

`ifdef DPWM_CAPTURE_SYNC_EN
  logic r_s1;
  logic r_s2;

  // two-flop synchronizer for an asynchronous gate input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign w_lvl = r_s2;
`else
  assign w_lvl = i_d;
`endif

  // previous sample, compared with the current one for edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_prev <= 1'b0;
    else          r_prev <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/dpwm_capture.sv
// dpwm_capture: loopback measurement of c1/c2 gate timing.
// Define DPWM_CAPTURE_SYNC_EN to synchronize c1/c2.
module dpwm_capture
  import dpwm_pkg::*;
#(
  parameter int TON_W = dpwm_pkg::TON_W,
  parameter int DT_W  = dpwm_pkg::DT_W,
  parameter int PER_W = dpwm_pkg::PER_W
) (
  input  logic           i_clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           c1,
  input  logic           c2,
  dpwm_capture_if.master m
);

  logic w_c1, w_c1_r, w_c1_f;
  logic w_c2, w_c2_r, w_c2_f;
  logic w_p1, w_p2, w_shoot;

  cap_st_t r_st, w_st_n;
  logic [TON_W-1:0] r_cton, w_cton_n, w_ton_inc;
  logic [TON_W-1:0] r_ctoff, w_ctoff_n, w_toff_inc;
  logic [DT_W-1:0]  r_cdt1, w_cdt1_n, w_dt1_inc;
  logic [DT_W-1:0]  r_cdt2, w_cdt2_n, w_dt2_inc;
  logic [PER_W-1:0] r_cper, w_cper_n, w_per_inc;
  logic r_sat, w_sat_n;
  logic w_pub, w_err, w_seq, w_hit, w_restart;

  logic [TON_W-1:0] r_ton, r_toff;
  logic [DT_W-1:0]  r_dt1, r_dt2;
  logic [PER_W-1:0] r_per;
  logic r_valid, r_err;

  dpwm_edge_sync u_c1 (
    .i_clk   (i_clk),
    .i_rst_n (reset_n),
    .i_d     (c1),
    .o_lvl   (w_c1),
    .o_rise  (w_c1_r),
    .o_fall  (w_c1_f)
  );

  dpwm_edge_sync u_c2 (
    .i_clk   (i_clk),
    .i_rst_n (reset_n),
    .i_d     (c2),
    .o_lvl   (w_c2),
    .o_rise  (w_c2_r),
    .o_fall  (w_c2_f)
  );

  // overlap flagged only on the first both-high sample
  assign w_p1    = w_c1 ^ (w_c1_r | w_c1_f);
  assign w_p2    = w_c2 ^ (w_c2_r | w_c2_f);
  assign w_shoot = w_c1 & w_c2 & ~(w_p1 & w_p2);

  assign w_ton_inc  = TON_W'(sat_inc(CNT_W'(r_cton), TON_W));
  assign w_toff_inc = TON_W'(sat_inc(CNT_W'(r_ctoff), TON_W));
  assign w_dt1_inc  = DT_W'(sat_inc(CNT_W'(r_cdt1), DT_W));
  assign w_dt2_inc  = DT_W'(sat_inc(CNT_W'(r_cdt2), DT_W));
  assign w_per_inc  = PER_W'(sat_inc(CNT_W'(r_cper), PER_W));

  // next state, counters, publish and error decisions
  always_comb begin
    w_st_n    = r_st;
    w_cton_n  = r_cton;
    w_ctoff_n = r_ctoff;
    w_cdt1_n  = r_cdt1;
    w_cdt2_n  = r_cdt2;
    w_cper_n  = r_cper;
    w_sat_n   = r_sat;
    w_pub     = 1'b0;
    w_err     = 1'b0;
    w_seq     = 1'b0;
    w_hit     = 1'b0;
    w_restart = 1'b0;
    unique case (r_st)
      IDLE: begin
        if (w_c1_r && !w_c2) w_restart = 1'b1;
      end
      C1_ON: begin
        w_cper_n = w_per_inc;
        w_hit    = &r_cper;
        if (w_c1_f) begin
          if (w_c2_r) begin
            w_st_n    = C2_ON;
            w_ctoff_n = TON_W'(1);
          end else begin
            w_st_n   = DT1;
            w_cdt1_n = DT_W'(1);
          end
        end else begin
          w_cton_n = w_ton_inc;
          w_hit    = w_hit | (&r_cton);
        end
      end
      DT1: begin
        w_cper_n = w_per_inc;
        w_hit    = &r_cper;
        if (w_c1_r) begin
          w_seq = 1'b1;
        end else if (w_c2_r) begin
          w_st_n    = C2_ON;
          w_ctoff_n = TON_W'(1);
        end else begin
          w_cdt1_n = w_dt1_inc;
          w_hit    = w_hit | (&r_cdt1);
        end
      end
      C2_ON: begin
        w_cper_n = w_per_inc;
        w_hit    = &r_cper;
        if (w_c2_f) begin
          if (w_c1_r) begin
            w_pub = 1'b1;
          end else begin
            w_st_n   = DT2;
            w_cdt2_n = DT_W'(1);
          end
        end else if (w_c1_r) begin
          w_seq = 1'b1;
        end else begin
          w_ctoff_n = w_toff_inc;
          w_hit     = w_hit | (&r_ctoff);
        end
      end
      DT2: begin
        if (w_c1_r) begin
          w_pub = 1'b1;
        end else begin
          w_cper_n = w_per_inc;
          w_hit    = &r_cper;
          if (w_c2_r) begin
            w_seq = 1'b1;
          end else begin
            w_cdt2_n = w_dt2_inc;
            w_hit    = w_hit | (&r_cdt2);
          end
        end
      end
      default: w_st_n = IDLE;
    endcase
    if (w_pub) w_restart = 1'b1;
    if (w_hit && !r_sat && !w_restart) begin
      w_sat_n = 1'b1;
      w_err   = 1'b1;
    end
    if (w_restart) begin
      w_st_n    = C1_ON;
      w_cton_n  = TON_W'(1);
      w_ctoff_n = '0;
      w_cdt1_n  = '0;
      w_cdt2_n  = '0;
      w_cper_n  = PER_W'(1);
      w_sat_n   = 1'b0;
    end
    if (w_shoot || w_seq) begin
      w_err = 1'b1;
      w_pub = 1'b0;
    end
    if (w_shoot || w_seq || !enable) begin
      w_st_n    = IDLE;
      w_cton_n  = '0;
      w_ctoff_n = '0;
      w_cdt1_n  = '0;
      w_cdt2_n  = '0;
      w_cper_n  = '0;
      w_sat_n   = 1'b0;
    end
    if (!enable) begin
      w_err = 1'b0;
      w_pub = 1'b0;
    end
  end

  // state and running counters
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st    <= IDLE;
      r_cton  <= '0;
      r_ctoff <= '0;
      r_cdt1  <= '0;
      r_cdt2  <= '0;
      r_cper  <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_st    <= w_st_n;
      r_cton  <= w_cton_n;
      r_ctoff <= w_ctoff_n;
      r_cdt1  <= w_cdt1_n;
      r_cdt2  <= w_cdt2_n;
      r_cper  <= w_cper_n;
      r_sat   <= w_sat_n;
    end
  end

  // published results and one-cycle pulses
  always_ff @(posedge i_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ton   <= '0;
      r_toff  <= '0;
      r_dt1   <= '0;
      r_dt2   <= '0;
      r_per   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= w_pub;
      r_err   <= w_err;
      if (w_pub) begin
        r_ton  <= r_cton;
        r_toff <= r_ctoff;
        r_dt1  <= r_cdt1;
        r_dt2  <= r_cdt2;
        r_per  <= r_cper;
      end
    end
  end

  assign m.o_ton    = r_ton;
  assign m.o_dt1    = r_dt1;
  assign m.o_toff   = r_toff;
  assign m.o_dt2    = r_dt2;
  assign m.o_period = r_per;
  assign m.o_valid  = r_valid;
  assign m.o_err    = r_err;

endmodule
